// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Multi-cycle instruction sequencer. Each instruction is fetched from
// instruction memory, decoded, executed and written back. On a HALT opcode,
// or on an undefined opcode, the unit stops and stays stopped until RESET.
//
// Instruction word layout:
//   [31:24] opcode   [18:16] dest   [10:8] src1   [2:0] src2   [7:0] imm
//
// Opcodes:
//   8'h00 LOADI  alu 000, immediate replaces DATA1
//   8'h01 MOV    alu 000
//   8'h02 ADD    alu 001
//   8'h03 AND    alu 010
//   8'h04 OR     alu 011
//   HALT_OPCODE  stop sequencing (checked first)
//   anything else: illegal, stop sequencing
//
// State sequence:
//   IDLE -> FETCH (waits for imem_ready) -> DECODE -> EXECUTE -> WRITEBACK -> FETCH
//   DECODE -> HALT on a HALT or undefined opcode
//
// Ports:
//   clk           in   clock, rising edge active
//   RESET         in   asynchronous, active-high reset
//   imem_rdata    in   32-bit instruction word
//   imem_ready    in   imem_rdata valid for the current request
//   imem_req      out  fetch request (high for the whole FETCH state)
//   imem_addr     out  fetch address (same as pc_out)
//   pc_out        out  program counter
//   alu_select    out  ALU operation select
//   imm_sel       out  immediate replaces the ALU DATA1 operand
//   imm_value     out  immediate field of the latched instruction
//   reg_out1addr  out  register-file read address 1 (src1)
//   reg_out2addr  out  register-file read address 2 (src2)
//   reg_inaddr    out  register-file write address (dest)
//   reg_we        out  register-file write enable, one pulse in WRITEBACK
//   halted        out  sequencer stopped
//   illegal       out  sticky: an undefined opcode was fetched
//
// Every output is driven directly by a flip-flop. There is no combinational
// path from imem_rdata or imem_ready to any output.
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int         PC_WIDTH    = 9,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [2:0]          alu_select,
  output logic                imm_sel,
  output logic [7:0]          imm_value,
  output logic [2:0]          reg_out1addr,
  output logic [2:0]          reg_out2addr,
  output logic [2:0]          reg_inaddr,
  output logic                reg_we,
  output logic                halted,
  output logic                illegal
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;

  // ---------------------------------------------------------------------------
  // Opcodes and ALU selects
  // ---------------------------------------------------------------------------
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_AND   = 8'h03;
  localparam logic [7:0] OP_OR    = 8'h04;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]          state_q,      state_d;
  logic [PC_WIDTH-1:0] pc_q,         pc_d;
  logic [31:0]         instr_q,      instr_d;
  logic [2:0]          alu_select_q, alu_select_d;
  logic                imm_sel_q,    imm_sel_d;
  logic                imem_req_q,   imem_req_d;
  logic                reg_we_q,     reg_we_d;
  logic                halted_q,     halted_d;
  logic                illegal_q,    illegal_d;

  // ---------------------------------------------------------------------------
  // Opcode decoder. HALT_OPCODE takes priority over the defined opcodes, so a
  // parameter value that collides with one of them still stops the sequencer.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       is_halt;
    logic       is_legal;
    logic       imm;
    logic [2:0] alu;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [7:0] op);
    op_info_t info;
    info.is_halt  = (op == HALT_OPCODE);
    info.is_legal = 1'b0;
    info.imm      = 1'b0;
    info.alu      = ALU_PASS;
    if (!info.is_halt) begin
      case (op)
        OP_LOADI: begin
          info.is_legal = 1'b1;
          info.imm      = 1'b1;
          info.alu      = ALU_PASS;
        end
        OP_MOV: begin
          info.is_legal = 1'b1;
          info.alu      = ALU_PASS;
        end
        OP_ADD: begin
          info.is_legal = 1'b1;
          info.alu      = ALU_ADD;
        end
        OP_AND: begin
          info.is_legal = 1'b1;
          info.alu      = ALU_AND;
        end
        OP_OR: begin
          info.is_legal = 1'b1;
          info.alu      = ALU_OR;
        end
        default: begin
          info.is_legal = 1'b0;
        end
      endcase
    end
    return info;
  endfunction

  op_info_t fetch_info;    // decode of the word being accepted from memory
  op_info_t latched_info;  // decode of the latched instruction
  logic     fetch_accept;

  assign fetch_info   = decode_op(imem_rdata[31:24]);
  assign latched_info = decode_op(instr_q[31:24]);

  // imem_ready only counts while a request is outstanding, i.e. in FETCH.
  assign fetch_accept = (state_q == ST_FETCH) && imem_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (latched_info.is_halt || !latched_info.is_legal) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_d      = instr_q;
    imm_sel_d    = imm_sel_q;
    alu_select_d = alu_select_q;
    pc_d         = pc_q;
    illegal_d    = illegal_q;

    // The instruction and its immediate-select flag are captured together,
    // so the register addresses and immediate are valid for the whole DECODE
    // state and remain stable until the next fetch is accepted.
    if (fetch_accept) begin
      instr_d   = imem_rdata;
      imm_sel_d = fetch_info.imm;
    end

    // alu_select is loaded on the DECODE->EXECUTE edge and held through
    // WRITEBACK.
    if ((state_q == ST_DECODE) && (state_d == ST_EXECUTE)) begin
      alu_select_d = latched_info.alu;
    end

    if ((state_q == ST_DECODE) && !latched_info.is_halt && !latched_info.is_legal) begin
      illegal_d = 1'b1;
    end

    // The PC advances only after a completed write-back. The counter wraps
    // naturally at 2^PC_WIDTH.
    if (state_q == ST_WRITEBACK) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end
  end

  // These flags are a direct function of the state being entered, which
  // keeps them registered while exactly matching the state they describe.
  assign imem_req_d = (state_d == ST_FETCH);
  assign reg_we_d   = (state_d == ST_WRITEBACK);
  assign halted_d   = (state_d == ST_HALT);

  // ---------------------------------------------------------------------------
  // Sequential state. The asynchronous reset clears reg_we at once, so a
  // reset during WRITEBACK cannot complete a partial write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      alu_select_q <= '0;
      imm_sel_q    <= 1'b0;
      imem_req_q   <= 1'b0;
      reg_we_q     <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      alu_select_q <= alu_select_d;
      imm_sel_q    <= imm_sel_d;
      imem_req_q   <= imem_req_d;
      reg_we_q     <= reg_we_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers
  // ---------------------------------------------------------------------------
  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc_out       = pc_q;
  assign alu_select   = alu_select_q;
  assign imm_sel      = imm_sel_q;
  assign imm_value    = instr_q[7:0];
  assign reg_out1addr = instr_q[10:8];
  assign reg_out2addr = instr_q[2:0];
  assign reg_inaddr   = instr_q[18:16];
  assign reg_we       = reg_we_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;

  // Reserved instruction bits carry no meaning in this instruction set.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_q[23:19], instr_q[15:11]};

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Self-checking bench for control_unit. It drives an instruction stream
// (directed cases followed by randomized opcodes, operand fields and fetch
// stalls). Expected behaviour comes from a per-instruction reference model:
// an opcode table plus the fetch/decode/execute/write-back cycle timing and
// the PC arithmetic. Prints one line per instruction transaction.
// -----------------------------------------------------------------------------
module tb_control_unit;

  localparam int         PW      = 9;
  localparam logic [7:0] HALT_OP = 8'hFF;

  logic          clk = 1'b0;
  logic          RESET;
  logic [31:0]   imem_rdata;
  logic          imem_ready;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [PW-1:0] pc_out;
  logic [2:0]    alu_select;
  logic          imm_sel;
  logic [7:0]    imm_value;
  logic [2:0]    reg_out1addr;
  logic [2:0]    reg_out2addr;
  logic [2:0]    reg_inaddr;
  logic          reg_we;
  logic          halted;
  logic          illegal;

  control_unit #(
    .PC_WIDTH   (PW),
    .HALT_OPCODE(HALT_OP)
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc_out      (pc_out),
    .alu_select  (alu_select),
    .imm_sel     (imm_sel),
    .imm_value   (imm_value),
    .reg_out1addr(reg_out1addr),
    .reg_out2addr(reg_out2addr),
    .reg_inaddr  (reg_inaddr),
    .reg_we      (reg_we),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int we_count = 0;
  int exp_pc   = 0;

  // Count write pulses on the opposite edge.
  always @(negedge clk) begin
    if (reg_we === 1'b1) we_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference opcode table.
  task automatic ref_decode(input logic [7:0] op, output bit is_halt, output bit is_legal,
                            output logic [2:0] alu, output bit imm);
    is_halt  = (op == HALT_OP);
    is_legal = !is_halt && (op <= 8'h04);
    imm      = is_legal && (op == 8'h00);
    case (op)
      8'h02:   alu = 3'b001;
      8'h03:   alu = 3'b010;
      8'h04:   alu = 3'b011;
      default: alu = 3'b000;
    endcase
  endtask

  task automatic check_all_zero(input string where);
    check_eq({where, "_req"},     imem_req, 0);
    check_eq({where, "_pc"},      pc_out, 0);
    check_eq({where, "_addr"},    imem_addr, 0);
    check_eq({where, "_alu"},     alu_select, 0);
    check_eq({where, "_imm"},     {imm_sel, imm_value}, 0);
    check_eq({where, "_regaddr"}, {reg_out1addr, reg_out2addr, reg_inaddr}, 0);
    check_eq({where, "_we"},      reg_we, 0);
    check_eq({where, "_flags"},   {halted, illegal}, 0);
  endtask

  // Reset, check that everything is zero, release on a falling edge, and
  // leave the DUT in its first FETCH cycle.
  task automatic do_reset();
    RESET      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    #2;
    check_all_zero("rst_async");
    @(posedge clk); #1;
    check_all_zero("rst_held");
    @(negedge clk);
    RESET  = 1'b0;
    exp_pc = 0;
    @(posedge clk); #1;
    check_eq("rst_first_fetch_req", imem_req, 1);
    check_eq("rst_first_fetch_addr", imem_addr, 0);
  endtask

  // Run one instruction. Entry: 1 time unit after the edge that started FETCH.
  task automatic run_instr(input logic [31:0] instr, input int stalls, input bit rst_in_wb,
                           output bit stopped);
    bit         is_halt, is_legal, imm;
    logic [2:0] alu;
    int         we0;
    ref_decode(instr[31:24], is_halt, is_legal, alu, imm);
    stopped = 1'b0;
    $display("instr pc=%0d word=%08h stalls=%0d halt=%0d legal=%0d rst_wb=%0d",
             exp_pc, instr, stalls, is_halt, is_legal, rst_in_wb);
    we0 = we_count;

    check_eq("fetch_req", imem_req, 1);
    check_eq("fetch_addr", imem_addr, exp_pc);
    check_eq("fetch_pc", pc_out, exp_pc);
    check_eq("fetch_we", reg_we, 0);

    for (int s = 0; s < stalls; s++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(posedge clk); #1;
      check_eq("stall_req", imem_req, 1);
      check_eq("stall_we", reg_we, 0);
      check_eq("stall_addr", imem_addr, exp_pc);
    end

    imem_rdata = instr;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    // DECODE: memory inputs become noise and must be ignored.
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    check_eq("dec_req", imem_req, 0);
    check_eq("dec_we", reg_we, 0);
    check_eq("dec_out1", reg_out1addr, instr[10:8]);
    check_eq("dec_out2", reg_out2addr, instr[2:0]);
    check_eq("dec_in", reg_inaddr, instr[18:16]);
    check_eq("dec_immv", imm_value, instr[7:0]);
    check_eq("dec_imms", imm_sel, imm);

    @(posedge clk); #1;
    if (is_halt || !is_legal) begin
      for (int c = 0; c < 5; c++) begin
        check_eq("halt_halted", halted, 1);
        check_eq("halt_illegal", illegal, !is_legal && !is_halt);
        check_eq("halt_req", imem_req, 0);
        check_eq("halt_we", reg_we, 0);
        check_eq("halt_pc", pc_out, exp_pc);
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        @(posedge clk); #1;
      end
      check_eq("halt_we_count", we_count - we0, 0);
      stopped = 1'b1;
      return;
    end

    // EXECUTE
    imem_ready = 1'($urandom);
    check_eq("ex_alu", alu_select, alu);
    check_eq("ex_we", reg_we, 0);
    check_eq("ex_flags", {halted, illegal}, 0);
    check_eq("ex_req", imem_req, 0);

    @(posedge clk); #1;
    // WRITEBACK
    check_eq("wb_we", reg_we, 1);
    check_eq("wb_alu", alu_select, alu);
    check_eq("wb_addrs", {reg_out1addr, reg_out2addr, reg_inaddr},
             {instr[10:8], instr[2:0], instr[18:16]});
    check_eq("wb_imm", {imm_sel, imm_value}, {imm, instr[7:0]});
    check_eq("wb_pc", pc_out, exp_pc);

    if (rst_in_wb) begin
      RESET = 1'b1;
      #1;
      check_eq("rstwb_we", reg_we, 0);
      check_eq("rstwb_pc", pc_out, 0);
      check_eq("rstwb_req", imem_req, 0);
      check_eq("rstwb_alu", alu_select, 0);
      @(negedge clk);
      check_eq("rstwb_we_count", we_count - we0, 0);
      RESET  = 1'b0;
      exp_pc = 0;
      @(posedge clk); #1;
      check_eq("rstwb_refetch_addr", imem_addr, 0);
      check_eq("rstwb_refetch_req", imem_req, 1);
      return;
    end

    @(posedge clk); #1;
    exp_pc = (exp_pc + 1) % (1 << PW);
    check_eq("next_pc", pc_out, exp_pc);
    check_eq("next_addr", imem_addr, exp_pc);
    check_eq("next_req", imem_req, 1);
    check_eq("next_we", reg_we, 0);
    check_eq("we_pulses", we_count - we0, 1);
  endtask

  function automatic logic [31:0] rand_word(input logic [7:0] op);
    logic [31:0] w;
    w = $urandom;
    w[31:24] = op;
    return w;
  endfunction

  initial begin
    bit          stopped;
    logic [7:0]  op;
    logic [31:0] w;
    RESET      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;

    do_reset();

    // LOADI r1,#5 ; ADD r3,r1,r2 ; MOV with three stall cycles.
    run_instr(32'h0001_0005, 0, 1'b0, stopped);
    run_instr(32'h0203_0102, 0, 1'b0, stopped);
    run_instr(32'h0105_0600, 3, 1'b0, stopped);

    // Long random run of legal instructions; passes the PC wrap with a MOV at 511.
    for (int i = 0; i < 520; i++) begin
      op = 8'($urandom_range(0, 4));
      if (exp_pc == (1 << PW) - 1) op = 8'h01;
      run_instr(rand_word(op), $urandom_range(0, 2), 1'b0, stopped);
    end

    // Illegal opcode.
    run_instr(rand_word(8'h7A), 1, 1'b0, stopped);
    check_eq("illegal_stopped", stopped, 1);
    do_reset();

    // Reset during WRITEBACK, then continue from address 0, then HALT.
    run_instr(32'h0002_0011, 0, 1'b0, stopped);
    run_instr(32'h0203_0102, 0, 1'b1, stopped);
    run_instr(32'h0304_0506, 1, 1'b0, stopped);
    run_instr(rand_word(HALT_OP), 0, 1'b0, stopped);
    do_reset();

    // Random mix including HALT and undefined opcodes.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       op = HALT_OP;
        1:       op = 8'($urandom_range(5, 254));
        default: op = 8'($urandom_range(0, 4));
      endcase
      w = rand_word(op);
      run_instr(w, $urandom_range(0, 3), ($urandom_range(0, 15) == 0), stopped);
      if (stopped) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 9, the program-counter and instruction-address width.
REQ-002 SHALL have parameter HALT_OPCODE, default 8'hFF, the opcode that stops sequencing.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_rdata  input  32  instruction word from instruction memory.
REQ-006 SHALL have port imem_ready  input  1  instruction memory has valid imem_rdata for the current request.
REQ-007 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  output  PC_WIDTH  fetch address, always equal to pc_out.
REQ-009 SHALL have port pc_out  output  PC_WIDTH  current program counter.
REQ-010 SHALL have port alu_select  output  3  ALU operation select (000 pass, 001 add, 010 and, 011 or).
REQ-011 SHALL have port imm_sel  output  1  1 = immediate replaces the ALU DATA1 operand.
REQ-012 SHALL have port imm_value  output  8  immediate field of the current instruction.
REQ-013 SHALL have port reg_out1addr, reg_out2addr, reg_inaddr  output  3 each  register-file read and write addresses.
REQ-014 SHALL have port reg_we  output  1  register-file write enable, one-cycle pulse per writing instruction.
REQ-015 SHALL have port halted  output  1  sequencer stopped (HALT or illegal opcode).
REQ-016 SHALL have port illegal  output  1  sticky flag: undefined opcode fetched.

Function
REQ-017 SHALL decode the instruction fields as opcode [31:24], dest [18:16], src1 [10:8], src2 [2:0] and imm [7:0].
REQ-018 SHALL decode 8'h00 LOADI (alu 000, imm_sel 1), 01 MOV (000, imm_sel 0), 02 ADD (001), 03 AND (010) and 04 OR (011), with imm_sel 0 except for LOADI.
REQ-019 SHALL implement the states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT, with IDLE->FETCH on the first edge after RESET deasserts.
REQ-020 SHALL hold imem_req high for the whole FETCH state and stay in FETCH until imem_ready is sampled high; it then latches imem_rdata and moves to DECODE.
REQ-021 SHALL ignore imem_ready whenever imem_req is low.
REQ-022 SHALL, in DECODE, drive reg_out1addr=src1, reg_out2addr=src2, reg_inaddr=dest, imm_value and imm_sel from the latched instruction and hold them stable through WRITEBACK.
REQ-023 SHALL, in DECODE, go to HALT when the opcode is HALT_OPCODE, or set illegal and go to HALT when the opcode is undefined; it SHALL otherwise go to EXECUTE.
REQ-024 SHALL, in EXECUTE, drive alu_select for the opcode and go to WRITEBACK on the next edge.
REQ-025 SHALL assert reg_we only in WRITEBACK, for exactly one cycle, with alu_select and all addresses unchanged.
REQ-026 SHALL, on leaving WRITEBACK, increment pc_out by 1 modulo 2^PC_WIDTH (the maximum value wraps to 0) and return to FETCH.
REQ-027 SHALL give a minimum instruction latency of 4 cycles (FETCH with ready, DECODE, EXECUTE, WRITEBACK); each stall cycle in FETCH adds one cycle.
REQ-028 SHALL, in HALT, hold halted=1, imem_req=0, reg_we=0 and pc_out frozen until RESET.
REQ-029 SHALL never change pc_out on a HALT or illegal instruction.
REQ-030 SHALL register all outputs, with no combinational path from imem_rdata or imem_ready to any output.

Reset
REQ-031 SHALL, while RESET is high and independent of clk, force state IDLE, pc_out 0, the latched instruction 0 and every output 0 (including illegal and halted).
REQ-032 SHALL, when RESET asserts mid-instruction, drop reg_we immediately so that no partial write occurs, and re-fetch from address 0 after release.

Verification
REQ-033 SHALL be verified by: reset, then LOADI r1,#5 with imem_ready=1 in the first FETCH cycle -> reg_we pulses in cycle 4 with inaddr=1, imm_value=5, imm_sel=1, alu_select=000; pc_out becomes 1.
REQ-034 SHALL be verified by: ADD r3,r1,r2 -> out1addr=1, out2addr=2, inaddr=3, alu_select=001, a single reg_we pulse, and pc incremented.
REQ-035 SHALL be verified by: imem_ready held low for 3 cycles in FETCH -> imem_req stays 1, no reg_we, and the instruction completes 3 cycles later than the 4-cycle minimum.
REQ-036 SHALL be verified by: opcode 8'h7A -> illegal=1 and halted=1, no reg_we, pc_out unchanged, imem_req 0 for all following cycles.
REQ-037 SHALL be verified by: MOV executed at pc_out=511 (PC_WIDTH=9) -> pc_out=0 and imem_addr=0 on the next FETCH.
REQ-038 SHALL be verified by: RESET asserted during WRITEBACK -> reg_we falls immediately, pc_out=0, and the next fetch after release is at address 0.
